// File: rtl/pipelined_shifter_if.sv
// Request/result handshake bundle for pipelined_shifter: operand, shift
// amount and mode flow in; result and carry-outs flow back with their own handshake.
interface pipelined_shifter_if #(parameter int WIDTH = 32);
   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH-1:0] A;
   logic [SHW-1:0]   SH;
   logic [1:0]       S;
   logic             InValid;
   logic             InReady;
   logic [WIDTH-1:0] AOut;
   logic             LCO;
   logic             RCO;
   logic             OutValid;
   logic             OutReady;

   modport master (
      output A, SH, S, InValid, OutReady,
      input  InReady, AOut, LCO, RCO, OutValid
   );

   modport slave (
      input  A, SH, S, InValid, OutReady,
      output InReady, AOut, LCO, RCO, OutValid
   );
endinterface

// File: rtl/pipelined_shifter.sv
// Two-stage valid/ready barrel shifter: stage 1 captures the request,
// stage 2 holds the shifted result with its left/right carry-out bits.
module pipelined_shifter #(
   parameter int WIDTH = 32
) (
   input logic                CLK,
   input logic                RST_N,
   pipelined_shifter_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      MODE_LSL = 2'b00,
      MODE_LSR = 2'b01,
      MODE_ASR = 2'b10,
      MODE_ROR = 2'b11
   } mode_e;

   logic               valid1_q, valid1_d;
   logic [WIDTH-1:0]   operand1_q, operand1_d;
   logic [SHW-1:0]     amount1_q, amount1_d;
   mode_e              mode1_q, mode1_d;

   logic               valid2_q, valid2_d;
   logic [WIDTH-1:0]   result2_q, result2_d;
   logic               lco2_q, lco2_d;
   logic               rco2_q, rco2_d;

   logic               load1;
   logic               load2;

   logic [WIDTH:0]        leftWide;
   logic [WIDTH:0]        rightWide;
   logic signed [WIDTH:0] arithWide;
   logic [2*WIDTH-1:0]    rotWide;
   logic [WIDTH-1:0]      shiftResult;
   logic                  shiftLco;
   logic                  shiftRco;

   // InReady depends only on pipeline state and OutReady, never on InValid.
   assign load2       = !valid2_q || bus.OutReady;
   assign load1       = !valid1_q || load2;
   assign bus.InReady = load1;

   // One guard bit on the exit side of each shift catches the last bit
   // shifted out; with a zero shift that guard bit stays 0 by construction.
   always_comb begin
      leftWide    = {1'b0, operand1_q} << amount1_q;
      rightWide   = {operand1_q, 1'b0} >> amount1_q;
      arithWide   = $signed({operand1_q, 1'b0}) >>> amount1_q;
      rotWide     = {operand1_q, operand1_q} >> amount1_q;
      shiftResult = operand1_q;
      shiftLco    = 1'b0;
      shiftRco    = 1'b0;
      case (mode1_q)
         MODE_LSL: begin
            shiftResult = leftWide[WIDTH-1:0];
            shiftLco    = leftWide[WIDTH];
         end
         MODE_LSR: begin
            shiftResult = rightWide[WIDTH:1];
            shiftRco    = rightWide[0];
         end
         MODE_ASR: begin
            shiftResult = arithWide[WIDTH:1];
            shiftRco    = arithWide[0];
         end
         MODE_ROR: begin
            shiftResult = rotWide[WIDTH-1:0];
            shiftRco    = rightWide[0];
         end
         default: begin
            shiftResult = operand1_q;
         end
      endcase
   end

   // Carry-outs are masked with the stage-1 valid so an emptied output stage shows zero flags.
   always_comb begin
      valid1_d   = valid1_q;
      operand1_d = operand1_q;
      amount1_d  = amount1_q;
      mode1_d    = mode1_q;
      valid2_d   = valid2_q;
      result2_d  = result2_q;
      lco2_d     = lco2_q;
      rco2_d     = rco2_q;
      if (load1) begin
         valid1_d = bus.InValid;
         if (bus.InValid) begin
            operand1_d = bus.A;
            amount1_d  = bus.SH;
            mode1_d    = mode_e'(bus.S);
         end
      end
      if (load2) begin
         valid2_d  = valid1_q;
         result2_d = shiftResult;
         lco2_d    = shiftLco & valid1_q;
         rco2_d    = shiftRco & valid1_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         valid1_q   <= 1'b0;
         operand1_q <= '0;
         amount1_q  <= '0;
         mode1_q    <= MODE_LSL;
         valid2_q   <= 1'b0;
         result2_q  <= '0;
         lco2_q     <= 1'b0;
         rco2_q     <= 1'b0;
      end else begin
         valid1_q   <= valid1_d;
         operand1_q <= operand1_d;
         amount1_q  <= amount1_d;
         mode1_q    <= mode1_d;
         valid2_q   <= valid2_d;
         result2_q  <= result2_d;
         lco2_q     <= lco2_d;
         rco2_q     <= rco2_d;
      end
   end

   assign bus.OutValid = valid2_q;
   assign bus.AOut     = result2_q;
   assign bus.LCO      = lco2_q;
   assign bus.RCO      = rco2_q;
endmodule

// File: tb/tb_pipelined_shifter.sv
// Scenario bench for pipelined_shifter: directed cases plus a random
// valid/ready stream scored against a bit-level reference model.
module tb_pipelined_shifter;
   localparam int W    = 32;
   localparam int NREQ = 1000;

   typedef struct packed {
      logic [W-1:0] aout;
      logic         lco;
      logic         rco;
   } res_t;

   logic CLK;
   logic RST_N;
   int   checks;
   int   errors;

   pipelined_shifter_if #(.WIDTH(W)) bus ();

   pipelined_shifter #(.WIDTH(W)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Each result bit is picked from the source bit it must come from.
   function automatic res_t model(input logic [W-1:0] a, input int sh, input logic [1:0] s);
      res_t r;
      r = '0;
      for (int i = 0; i < W; i++) begin
         case (s)
            2'd0:    r.aout[i] = (i >= sh) ? a[i-sh] : 1'b0;
            2'd1:    r.aout[i] = (i + sh < W) ? a[i+sh] : 1'b0;
            2'd2:    r.aout[i] = (i + sh < W) ? a[i+sh] : a[W-1];
            default: r.aout[i] = a[(i+sh)%W];
         endcase
      end
      if (sh != 0) begin
         if (s == 2'd0) r.lco = a[W-sh];
         else           r.rco = a[sh-1];
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [W-1:0] a, input logic [4:0] sh, input logic [1:0] s);
      bus.A       = a;
      bus.SH      = sh;
      bus.S       = s;
      bus.InValid = 1'b1;
   endtask

   // Requests offered during reset must never come out.
   task automatic test_reset();
      RST_N        = 1'b0;
      bus.OutReady = 1'b1;
      drive(32'hDEADBEEF, 5'd3, 2'b00);
      tick();
      tick();
      #1;
      checks++;
      if ({bus.OutValid, bus.InReady, bus.LCO, bus.RCO, bus.AOut} !== {4'b0100, 32'h0}) begin
         errors++;
         $display("[TB] FAIL reset_state got v=%b rdy=%b l=%b r=%b a=%h exp v=0 rdy=1 l=0 r=0 a=00000000",
                  bus.OutValid, bus.InReady, bus.LCO, bus.RCO, bus.AOut);
      end
      RST_N       = 1'b1;
      bus.InValid = 1'b0;
      tick();
      #1;
      checks++;
      if ({bus.OutValid, bus.InReady} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL reset_release got v=%b rdy=%b exp v=0 rdy=1", bus.OutValid, bus.InReady);
      end
      tick();
      tick();
      #1;
      checks++;
      if (bus.OutValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_no_transfer got v=%b exp 0", bus.OutValid);
      end
   endtask

   task automatic test_lsl();
      bus.OutReady = 1'b1;
      drive(32'hFFFFFFFF, 5'd31, 2'b00);
      #1;
      tick();
      bus.InValid = 1'b0;
      #1;
      checks++;
      if (bus.OutValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL lsl_latency got v=%b exp 0 one edge after accept", bus.OutValid);
      end
      tick();
      #1;
      checks++;
      if ({bus.OutValid, bus.AOut, bus.LCO, bus.RCO} !== {1'b1, 32'h80000000, 2'b10}) begin
         errors++;
         $display("[TB] FAIL lsl_result got v=%b a=%h l=%b r=%b exp v=1 a=80000000 l=1 r=0",
                  bus.OutValid, bus.AOut, bus.LCO, bus.RCO);
      end
      tick();
      #1;
      checks++;
      if ({bus.OutValid, bus.LCO, bus.RCO} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL idle_flags got v=%b l=%b r=%b exp 0 0 0", bus.OutValid, bus.LCO, bus.RCO);
      end
   endtask

   task automatic test_lsr_asr();
      bus.OutReady = 1'b1;
      drive(32'hFFFFFFF0, 5'd7, 2'b01);
      #1;
      tick();
      drive(32'h80000000, 5'd4, 2'b10);
      #1;
      tick();
      bus.InValid = 1'b0;
      #1;
      checks++;
      if ({bus.OutValid, bus.AOut, bus.LCO, bus.RCO} !== {1'b1, 32'h01FFFFFF, 2'b01}) begin
         errors++;
         $display("[TB] FAIL lsr_result got v=%b a=%h l=%b r=%b exp v=1 a=01FFFFFF l=0 r=1",
                  bus.OutValid, bus.AOut, bus.LCO, bus.RCO);
      end
      tick();
      #1;
      checks++;
      if ({bus.OutValid, bus.AOut, bus.LCO, bus.RCO} !== {1'b1, 32'hF8000000, 2'b00}) begin
         errors++;
         $display("[TB] FAIL asr_result got v=%b a=%h l=%b r=%b exp v=1 a=F8000000 l=0 r=0",
                  bus.OutValid, bus.AOut, bus.LCO, bus.RCO);
      end
      tick();
   endtask

   task automatic test_ror_zero();
      bus.OutReady = 1'b1;
      drive(32'h00000001, 5'd1, 2'b11);
      #1;
      tick();
      drive(32'h0FFFFFFF, 5'd0, 2'b00);
      #1;
      tick();
      bus.InValid = 1'b0;
      #1;
      checks++;
      if ({bus.OutValid, bus.AOut, bus.LCO, bus.RCO} !== {1'b1, 32'h80000000, 2'b01}) begin
         errors++;
         $display("[TB] FAIL ror_result got v=%b a=%h l=%b r=%b exp v=1 a=80000000 l=0 r=1",
                  bus.OutValid, bus.AOut, bus.LCO, bus.RCO);
      end
      tick();
      #1;
      checks++;
      if ({bus.OutValid, bus.AOut, bus.LCO, bus.RCO} !== {1'b1, 32'h0FFFFFFF, 2'b00}) begin
         errors++;
         $display("[TB] FAIL zero_shift got v=%b a=%h l=%b r=%b exp v=1 a=0FFFFFFF l=0 r=0",
                  bus.OutValid, bus.AOut, bus.LCO, bus.RCO);
      end
      tick();
   endtask

   // The third request is held off until the stalled first result drains.
   task automatic test_backpressure();
      res_t e0, e1, e2;
      e0 = model(32'h12345678, 4, 2'b01);
      e1 = model(32'h87654321, 8, 2'b10);
      e2 = model(32'hF0F0F0F0, 12, 2'b11);
      bus.OutReady = 1'b0;
      drive(32'h12345678, 5'd4, 2'b01);
      #1;
      tick();
      drive(32'h87654321, 5'd8, 2'b10);
      #1;
      tick();
      drive(32'hF0F0F0F0, 5'd12, 2'b11);
      #1;
      checks++;
      if ({bus.InReady, bus.OutValid, bus.AOut, bus.LCO, bus.RCO} !== {2'b01, e0}) begin
         errors++;
         $display("[TB] FAIL bp_full got rdy=%b v=%b a=%h l=%b r=%b exp rdy=0 v=1 a=%h l=%b r=%b",
                  bus.InReady, bus.OutValid, bus.AOut, bus.LCO, bus.RCO, e0.aout, e0.lco, e0.rco);
      end
      tick();
      #1;
      checks++;
      if ({bus.InReady, bus.OutValid, bus.AOut, bus.LCO, bus.RCO} !== {2'b01, e0}) begin
         errors++;
         $display("[TB] FAIL bp_hold got rdy=%b v=%b a=%h l=%b r=%b exp rdy=0 v=1 a=%h l=%b r=%b",
                  bus.InReady, bus.OutValid, bus.AOut, bus.LCO, bus.RCO, e0.aout, e0.lco, e0.rco);
      end
      bus.OutReady = 1'b1;
      #1;
      checks++;
      if (bus.InReady !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_no_bubble got rdy=%b exp 1", bus.InReady);
      end
      tick();
      bus.InValid = 1'b0;
      #1;
      checks++;
      if ({bus.OutValid, bus.AOut, bus.LCO, bus.RCO} !== {1'b1, e1}) begin
         errors++;
         $display("[TB] FAIL bp_second got v=%b a=%h l=%b r=%b exp v=1 a=%h l=%b r=%b",
                  bus.OutValid, bus.AOut, bus.LCO, bus.RCO, e1.aout, e1.lco, e1.rco);
      end
      tick();
      #1;
      checks++;
      if ({bus.OutValid, bus.AOut, bus.LCO, bus.RCO} !== {1'b1, e2}) begin
         errors++;
         $display("[TB] FAIL bp_third got v=%b a=%h l=%b r=%b exp v=1 a=%h l=%b r=%b",
                  bus.OutValid, bus.AOut, bus.LCO, bus.RCO, e2.aout, e2.lco, e2.rco);
      end
      tick();
      #1;
      checks++;
      if (bus.OutValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_drained got v=%b exp 0", bus.OutValid);
      end
   endtask

   task automatic test_reset_mid();
      bus.OutReady = 1'b0;
      drive(32'hA5A5A5A5, 5'd3, 2'b00);
      #1;
      tick();
      drive(32'h5A5A5A5A, 5'd9, 2'b11);
      #1;
      tick();
      bus.InValid = 1'b0;
      RST_N       = 1'b0;
      #1;
      tick();
      RST_N        = 1'b1;
      bus.OutReady = 1'b1;
      #1;
      checks++;
      if ({bus.OutValid, bus.InReady, bus.LCO, bus.RCO} !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL midreset_state got v=%b rdy=%b l=%b r=%b exp v=0 rdy=1 l=0 r=0",
                  bus.OutValid, bus.InReady, bus.LCO, bus.RCO);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         #1;
         checks++;
         if (bus.OutValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_ghost cycle %0d got v=%b exp 0", i, bus.OutValid);
         end
      end
   endtask

   // Random handshakes; expected results queue in acceptance order.
   task automatic test_random();
      res_t q[$];
      res_t e;
      res_t prevOut;
      logic holdPrev;
      int   sent;
      int   recv;
      int   cycles;
      sent     = 0;
      recv     = 0;
      cycles   = 0;
      holdPrev = 1'b0;
      prevOut  = '0;
      while ((sent < NREQ || recv < NREQ) && cycles < 20000) begin
         bus.InValid  = (sent < NREQ) && ($urandom_range(0, 1) == 1);
         bus.A        = $urandom;
         bus.SH       = 5'($urandom);
         bus.S        = 2'($urandom);
         bus.OutReady = 1'($urandom_range(0, 1));
         #1;
         if (holdPrev) begin
            checks++;
            if ({bus.OutValid, bus.AOut, bus.LCO, bus.RCO} !== {1'b1, prevOut}) begin
               errors++;
               $display("[TB] FAIL rand_hold got v=%b a=%h exp v=1 a=%h", bus.OutValid, bus.AOut, prevOut.aout);
            end
         end
         if (bus.OutValid !== 1'b1) begin
            checks++;
            if ({bus.LCO, bus.RCO} !== 2'b00) begin
               errors++;
               $display("[TB] FAIL rand_idle_flags got l=%b r=%b exp 0 0", bus.LCO, bus.RCO);
            end
         end
         if (bus.OutValid === 1'b1 && bus.OutReady) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("[TB] FAIL rand_extra got a=%h exp no result", bus.AOut);
            end else begin
               e = q.pop_front();
               if ({bus.AOut, bus.LCO, bus.RCO} !== e) begin
                  errors++;
                  $display("[TB] FAIL rand_result #%0d got a=%h l=%b r=%b exp a=%h l=%b r=%b",
                           recv, bus.AOut, bus.LCO, bus.RCO, e.aout, e.lco, e.rco);
               end
            end
            recv++;
         end
         holdPrev = (bus.OutValid === 1'b1) && !bus.OutReady;
         prevOut  = {bus.AOut, bus.LCO, bus.RCO};
         if (bus.InValid && bus.InReady === 1'b1) begin
            q.push_back(model(bus.A, int'(bus.SH), bus.S));
            sent++;
         end
         tick();
         cycles++;
      end
      bus.InValid = 1'b0;
      checks++;
      if (cycles >= 20000 || q.size() != 0 || recv != NREQ) begin
         errors++;
         $display("[TB] FAIL rand_complete got sent=%0d recv=%0d left=%0d cycles=%0d exp recv=%0d left=0",
                  sent, recv, q.size(), cycles, NREQ);
      end
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      RST_N        = 1'b0;
      bus.A        = '0;
      bus.SH       = '0;
      bus.S        = '0;
      bus.InValid  = 1'b0;
      bus.OutReady = 1'b0;
      test_reset();
      test_lsl();
      test_lsr_asr();
      test_ror_zero();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog got timeout exp completion");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule

// File: doc/pipelined_shifter.md
PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32; datapath width, a power of two, at least 4.
REQ-002 SHALL derive localparam SHW = log2(WIDTH), default 5; the shift-amount width.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit: synchronous, active-low reset, sampled on the CLK rising edge.
REQ-005 SHALL have port A, input, WIDTH bits: operand.
REQ-006 SHALL have port SH, input, SHW bits: shift amount, 0..WIDTH-1.
REQ-007 SHALL have port S, input, 2 bits: mode; 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-008 SHALL have port InValid, input, 1 bit: A/SH/S hold a valid request.
REQ-009 SHALL have port InReady, output, 1 bit: the block accepts a request this cycle.
REQ-010 SHALL have port AOut, output, WIDTH bits: result.
REQ-011 SHALL have port LCO, output, 1 bit: last bit shifted out on the left.
REQ-012 SHALL have port RCO, output, 1 bit: last bit shifted out on the right.
REQ-013 SHALL have port OutValid, output, 1 bit: AOut/LCO/RCO hold a valid result.
REQ-014 SHALL have port OutReady, input, 1 bit: the consumer takes the result this cycle.

Function
REQ-015 SHALL accept a request on a rising edge where InValid && InReady; this is a transfer.
REQ-016 SHALL complete a result transfer on a rising edge where OutValid && OutReady.
REQ-017 SHALL be a two-stage pipeline, each stage holding a valid flag: stage 1 is the input/partial register, stage 2 is the output register.
REQ-018 SHALL use these advance rules: stage 2 loads when !v2 || OutReady; stage 1 loads when !v1 || (stage 2 loads).
REQ-019 SHALL drive InReady = !v1 || (!v2 || OutReady); this is combinational and no combinational path from InValid to InReady is permitted.
REQ-020 SHALL have a latency of 2: a request accepted at edge k gives OutValid=1 after edge k+1 when there is no backpressure; throughput is one result per cycle.
REQ-021 SHALL hold AOut, LCO, RCO and OutValid stable while OutValid && !OutReady.
REQ-022 SHALL deliver results in acceptance order, with no loss and no duplication under any InValid/OutReady pattern.
REQ-023 SHALL implement LSL as AOut = A << SH, zero fill, with LCO = A[WIDTH-SH] and RCO = 0.
REQ-024 SHALL implement LSR as AOut = A >> SH, zero fill, with RCO = A[SH-1] and LCO = 0.
REQ-025 SHALL implement ASR as AOut = A >> SH with A[WIDTH-1] fill, with RCO = A[SH-1] and LCO = 0.
REQ-026 SHALL implement ROR as AOut = A rotated right by SH, with RCO = A[SH-1] (bit wrapped into the MSB) and LCO = 0.
REQ-027 SHALL force LCO = RCO = 0 and AOut = A in every mode when SH = 0.
REQ-028 SHALL produce LCO = RCO = 0 when OutValid = 0; AOut is don't-care in that case.
REQ-029 SHALL let a request be accepted on the same edge that the stage-2 result is consumed when the pipeline is full, giving no bubble.
REQ-030 SHALL not use an SH value of WIDTH or more; this is not representable because SH is SHW bits wide.

Reset
REQ-031 SHALL, on an edge with RST_N = 0, clear v1 and v2, AOut, LCO and RCO to 0, regardless of InValid/OutReady.
REQ-032 SHALL drop in-flight requests when reset is applied mid-operation; no result from them appears after reset.
REQ-033 SHALL hold InReady = 1 and OutValid = 0 during reset and on the first cycle after release.
REQ-034 SHALL not transfer a request presented while RST_N = 0.

Verification
REQ-035 SHALL be covered by scenario LSL: A=FFFFFFFF, SH=31, S=00, OutReady=1 -> two edges later AOut=80000000, LCO=1, RCO=0.
REQ-036 SHALL be covered by scenario LSR then ASR back-to-back: (FFFFFFF0, 7, 01) then (80000000, 4, 10) -> consecutive results 01FFFFFF with RCO=1, then F8000000 with RCO=0.
REQ-037 SHALL be covered by scenario ROR and zero shift: (00000001, 1, 11) -> 80000000 with RCO=1; then (0FFFFFFF, 0, 00) -> 0FFFFFFF with LCO=RCO=0.
REQ-038 SHALL be covered by scenario backpressure: OutReady=0 and 3 requests offered -> 2 accepted, InReady=0, OutValid=1 with the first result stable; OutReady=1 -> all 3 results in order, one per cycle.
REQ-039 SHALL be covered by scenario reset mid-stream: 2 requests in flight, RST_N=0 for one edge -> OutValid=0, InReady=1, and neither result ever appears.
REQ-040 SHALL be covered by scenario random stream: random InValid/OutReady at 50% over 1000 requests -> every output matches a reference model, in order.
